// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: tracks destination writes of E/M/W and generates stall/bubble/flush/redirect.
// Optional RAW stall-cycle counter (stall_cnt port) is built only when HAZ_STALL_CNT_EN is defined.
module hazard_stall_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       d_valid,
  input  logic [3:0] d_rs1,
  input  logic [3:0] d_rs2,
  input  logic       d_use_rs1,
  input  logic       d_use_rs2,
  input  logic       d_wr_reg,
  input  logic [3:0] d_dst,
  input  logic       ex_br_taken,
  input  logic       mem_busy,
  output logic       hold,
  output logic       stall_f,
  output logic       stall_d,
  output logic       bubble_e,
  output logic       flush_d,
  output logic       pc_sel_br,
  output logic       e_valid,
  output logic       m_valid,
  output logic       w_valid
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [3:0] dst;
  } shadow_t;

  shadow_t e_q, e_d;
  shadow_t m_q, m_d;
  // W only needs occupancy: the register file is write-first, so its dst never causes a stall.
  logic    w_valid_q, w_valid_d;

  logic    match_rs1, match_rs2;
  logic    raw, br, raw_stall;

  always_comb begin
    match_rs1 = (e_q.valid && e_q.wr && (e_q.dst == d_rs1)) ||
                (m_q.valid && m_q.wr && (m_q.dst == d_rs1));
    match_rs2 = (e_q.valid && e_q.wr && (e_q.dst == d_rs2)) ||
                (m_q.valid && m_q.wr && (m_q.dst == d_rs2));
    raw       = d_valid && ((d_use_rs1 && match_rs1) || (d_use_rs2 && match_rs2));
    br        = e_q.valid && ex_br_taken;
    raw_stall = !mem_busy && !br && raw;
  end

  // Priority: memory freeze over branch redirect over RAW interlock.
  always_comb begin
    hold      = 1'b0;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    bubble_e  = 1'b0;
    flush_d   = 1'b0;
    pc_sel_br = 1'b0;
    if (mem_busy) begin
      hold    = 1'b1;
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else if (br) begin
      pc_sel_br = 1'b1;
      flush_d   = 1'b1;
      bubble_e  = 1'b1;
    end else if (raw) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      bubble_e = 1'b1;
    end
  end

  always_comb begin
    e_d       = e_q;
    m_d       = m_q;
    w_valid_d = w_valid_q;
    if (!mem_busy) begin
      w_valid_d = m_q.valid;
      m_d       = e_q;
      if (bubble_e) begin
        e_d = '0;
      end else begin
        e_d.valid = d_valid;
        e_d.wr    = d_wr_reg;
        e_d.dst   = d_dst;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q       <= '0;
      m_q       <= '0;
      w_valid_q <= 1'b0;
    end else begin
      e_q       <= e_d;
      m_q       <= m_d;
      w_valid_q <= w_valid_d;
    end
  end

  assign e_valid = e_q.valid;
  assign m_valid = m_q.valid;
  assign w_valid = w_valid_q;

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (raw_stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_raw_stall;
  assign unused_raw_stall = raw_stall;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: hand-computed expected outputs per cycle go through a queue.
module tb_hazard_stall_ctrl;

  localparam int W = 9;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       d_valid, d_use_rs1, d_use_rs2, d_wr_reg, ex_br_taken, mem_busy;
  logic [3:0] d_rs1, d_rs2, d_dst;
  logic       hold, stall_f, stall_d, bubble_e, flush_d, pc_sel_br;
  logic       e_valid, m_valid, w_valid;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  hazard_stall_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
    .d_wr_reg(d_wr_reg), .d_dst(d_dst),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .hold(hold), .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e),
    .flush_d(flush_d), .pc_sel_br(pc_sel_br),
    .e_valid(e_valid), .m_valid(m_valid), .w_valid(w_valid)
`ifdef HAZ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // {hold, stall_f, stall_d, bubble_e, flush_d, pc_sel_br, e_valid, m_valid, w_valid}
  function automatic logic [W-1:0] mk(input logic h, sf, sd, be, fd, pc, ev, mv, wv);
    return {h, sf, sd, be, fd, pc, ev, mv, wv};
  endfunction

  // driver
  task automatic drv(input logic v, input logic [3:0] rs1, input logic u1,
                     input logic [3:0] rs2, input logic u2,
                     input logic wr, input logic [3:0] dst,
                     input logic brt, input logic mb, input logic [W-1:0] exp_v);
    d_valid = v; d_rs1 = rs1; d_use_rs1 = u1; d_rs2 = rs2; d_use_rs2 = u2;
    d_wr_reg = wr; d_dst = dst; ex_br_taken = brt; mem_busy = mb;
    exp_q.push_back(exp_v);
  endtask

  // scoreboard
  task automatic chk(input string tag);
    logic [W-1:0] obs, exp_v;
    obs = {hold, stall_f, stall_d, bubble_e, flush_d, pc_sel_br, e_valid, m_valid, w_valid};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $display("FAIL %s: observed %b required an expected entry (queue empty)", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_fails++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp_c);
`ifdef HAZ_STALL_CNT_EN
    n_checks++;
    assert (stall_cnt === exp_c) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, stall_cnt, exp_c);
    end
`else
    if (tag.len() == 0 && exp_c == 32'd0) begin end
`endif
  endtask

  task automatic settle_and_check(input string tag);
    #2;
    chk(tag);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0));
    #1;
    chk("reset_idle_outputs");
    next_cycle();

    // reset held with a writing instruction in decode
    drv(1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0));
    settle_and_check("reset_c1");
    next_cycle();
    drv(1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1, mk(1,1,1,0,0,0,0,0,0));
    settle_and_check("reset_c2_mem_busy");
    next_cycle();
    drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0));
    settle_and_check("reset_c3");
    next_cycle();

    reset_n = 1'b1;
    drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0));
    settle_and_check("post_reset_empty");
    chk_cnt("post_reset_cnt", 32'd0);
    next_cycle();

    // RAW on E: writer of r3 then reader of r3
    drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0));
    settle_and_check("rawe_c0");
    next_cycle();
    drv(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, mk(0,1,1,1,0,0,1,0,0));
    settle_and_check("rawe_c1_stall");
    next_cycle();
    drv(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, mk(0,1,1,1,0,0,0,1,0));
    settle_and_check("rawe_c2_stall");
    next_cycle();
    drv(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,1));
    settle_and_check("rawe_c3_go");
    chk_cnt("rawe_cnt", 32'd2);
    next_cycle();

    // taken branch with E valid, then ex_br_taken with E empty is ignored
    drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, mk(0,0,0,1,1,1,1,0,0));
    settle_and_check("br_taken");
    next_cycle();
    drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,1,0));
    settle_and_check("br_ignored_e_empty");
    next_cycle();
    drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,1));
    settle_and_check("write_r7");
    next_cycle();

    // freeze with a pending RAW on M (r7)
    drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,1,0,0));
    settle_and_check("nowrite_instr");
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 4'd9, 1'b0, 1'b1, mk(1,1,1,0,0,0,1,1,0));
      settle_and_check($sformatf("freeze_c%0d", i));
      next_cycle();
    end
    chk_cnt("freeze_cnt", 32'd2);
    drv(1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, mk(0,1,1,1,0,0,1,1,0));
    settle_and_check("freeze_release_stall");
    next_cycle();
    drv(1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,1,1));
    settle_and_check("freeze_release_go");
    chk_cnt("freeze_release_cnt", 32'd3);
    next_cycle();

    // branch and RAW together: branch wins, no stall counted
    drv(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, mk(0,0,0,1,1,1,1,0,1));
    settle_and_check("br_and_raw");
    next_cycle();
    drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,1,0));
    settle_and_check("br_and_raw_after");
    chk_cnt("br_and_raw_cnt", 32'd3);
    next_cycle();
    drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,1));
    settle_and_check("drain");
    next_cycle();

    // reset during a RAW stall
    drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0));
    settle_and_check("midrst_write_r2");
    next_cycle();
    drv(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, mk(0,1,1,1,0,0,1,0,0));
    settle_and_check("midrst_stall");
    reset_n = 1'b0;
    exp_q.push_back(mk(0,0,0,0,0,0,0,0,0));
    #1;
    chk("midrst_async_clear");
    chk_cnt("midrst_cnt_clear", 32'd0);
    next_cycle();
    reset_n = 1'b1;
    drv(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0));
    settle_and_check("midrst_first_cycle");
    next_cycle();

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL queue_drain: observed %0d leftover entries required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide d_valid  input  1  decode stage holds a real instruction.
REQ-004 SHALL provide d_rs1, d_rs2  input  4 each  decode source register numbers.
REQ-005 SHALL provide d_use_rs1, d_use_rs2  input  1 each  source actually read (from decoder mux selects).
REQ-006 SHALL provide d_wr_reg  input  1 and d_dst  input  4  decode instruction writes register d_dst.
REQ-007 SHALL provide ex_br_taken  input  1  execute-stage instruction redirects the PC (taken branch or jump).
REQ-008 SHALL provide mem_busy  input  1  data memory not ready; whole pipeline freezes.
REQ-009 SHALL provide hold  output  1  all pipeline registers keep their value.
REQ-010 SHALL provide stall_f, stall_d  output  1 each  fetch PC / decode register keep their value.
REQ-011 SHALL provide bubble_e  output  1  execute register loads a NOP.
REQ-012 SHALL provide flush_d  output  1  decode register loads a NOP.
REQ-013 SHALL provide pc_sel_br  output  1  fetch takes the branch target.
REQ-014 SHALL provide e_valid, m_valid, w_valid  output  1 each  shadow-stage occupancy.
REQ-015 SHALL provide stall_cnt  output  32  RAW stall cycle count (only with HAZ_STALL_CNT_EN).

Function
REQ-016 SHALL keep a shadow pipeline E, M, W, each entry {valid, wr, dst[3:0]}.
REQ-017 SHALL define match(r) = (E.valid & E.wr & E.dst==r) | (M.valid & M.wr & M.dst==r); W is excluded because the register file is write-first; register 0 is not special.
REQ-018 SHALL define raw = d_valid & ((d_use_rs1 & match(d_rs1)) | (d_use_rs2 & match(d_rs2))).
REQ-019 SHALL define br = E.valid & ex_br_taken.
REQ-020 SHALL apply priority mem_busy > br > raw; all outputs combinational from state and inputs, zero latency.
REQ-021 SHALL, when mem_busy=1: hold=1, stall_f=1, stall_d=1, bubble_e=0, flush_d=0, pc_sel_br=0; shadow pipeline unchanged.
REQ-022 SHALL, when mem_busy=0 and br=1: pc_sel_br=1, flush_d=1, bubble_e=1, stall_f=0, stall_d=0, hold=0, regardless of raw.
REQ-023 SHALL, when mem_busy=0, br=0, raw=1: stall_f=1, stall_d=1, bubble_e=1, others 0.
REQ-024 SHALL otherwise drive all control outputs 0.
REQ-025 SHALL, on every edge with mem_busy=0, shift W<=M, M<=E, E<=bubble_e ? {0,0,0} : {d_valid,d_wr_reg,d_dst}.
REQ-026 SHALL resolve a RAW on E in exactly 2 stall cycles and on M in exactly 1.
REQ-027 SHALL ignore ex_br_taken when E.valid=0.

Reset
REQ-028 SHALL, while reset_n=0, clear all shadow valid/wr/dst bits and stall_cnt immediately, independent of clk.
REQ-029 SHALL therefore drive hold, stall_f, stall_d, bubble_e, flush_d, pc_sel_br, e/m/w_valid to 0 during and right after reset, unless mem_busy=1 (hold, stall_f, stall_d = 1).
REQ-030 SHALL, on reset asserted mid-stall, discard the in-flight hazard; the first post-reset cycle sees an empty shadow pipeline.

Configuration
REQ-031 SHALL compile stall_cnt only when HAZ_STALL_CNT_EN is defined: increments by 1 on each edge where raw stall per REQ-023 applies (not mem_busy, not br); wraps 0xFFFFFFFF->0.
REQ-032 SHALL, without HAZ_STALL_CNT_EN, omit the stall_cnt port and its register entirely; all other behaviour identical.

Verification
REQ-033 SHALL test reset: reset_n=0 with d_valid=1,d_wr_reg=1 for 3 cycles -> after release e/m/w_valid=0, all controls 0, stall_cnt=0.
REQ-034 SHALL test RAW-on-E: cycle0 D writes r3; cycle1 D reads rs1=r3 -> stall_d=1,bubble_e=1 in cycles 1 and 2, 0 in cycle 3; stall_cnt=2.
REQ-035 SHALL test branch: E.valid=1, ex_br_taken=1 -> pc_sel_br=flush_d=bubble_e=1 for one cycle; next cycle e_valid=0.
REQ-036 SHALL test freeze: pending RAW on M plus mem_busy=1 for 3 cycles -> hold=1, shadow unchanged, stall_cnt unchanged; after release exactly 1 stall cycle.
REQ-037 SHALL test simultaneous br and raw -> flush_d=1, stall_d=0, stall_cnt unchanged.
REQ-038 SHALL test reset asserted during a 2-cycle RAW stall (cycle 1) -> stall_d=0 immediately, e_valid=0.
